// File: rtl/gate_bank_tester.sv
// Stimulus/response tester for a two-input gate bank: walks {a,b} through all
// four vectors, samples the eight gate outputs and accumulates mismatch results.
module gate_bank_tester_lane (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic chk,
    input  logic exp_bit,
    input  logic got_bit,
    output logic mism,
    output logic fail
);
    assign mism = exp_bit ^ got_bit;

    // Sticky per-gate failure flag, cleared when a new test is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fail <= 1'b0;
        else if (clr)
            fail <= 1'b0;
        else if (chk && mism)
            fail <= 1'b1;
    end
endmodule

module gate_bank_tester #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] gate_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [7:0] fail_mask,
    output logic [1:0] first_fail_vec,
    output logic       first_fail_valid
);
    localparam int NUM_LANES = 8;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

    state_t                 state;
    logic [1:0]             vec;
    logic [1:0]             vec_nxt;
    logic [3:0]             settle_cnt;
    logic [NUM_LANES-1:0]   expected;
    logic [NUM_LANES-1:0]   mism;
    logic                   accept;
    logic                   checking;

    // Golden truth table, packed {xnor,xor,nor,nand,not_b,not_a,or,and}
    always_comb begin
        expected = 8'h00;
        case (vec)
            2'b00: expected = 8'hBC;
            2'b01: expected = 8'h56;
            2'b10: expected = 8'h5A;
            2'b11: expected = 8'h83;
        endcase
    end

    assign accept   = start && (state == IDLE || state == DONE);
    assign checking = (state == CHECK);
    assign vec_nxt  = vec + 2'd1;
    assign pass     = done && (err_count == 3'd0);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        gate_bank_tester_lane u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .clr     (accept),
            .chk     (checking),
            .exp_bit (expected[i]),
            .got_bit (gate_in[i]),
            .mism    (mism[i]),
            .fail    (fail_mask[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= 2'd0;
            settle_cnt       <= 4'd0;
            a_out            <= 1'b0;
            b_out            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            err_count        <= 3'd0;
            first_fail_vec   <= 2'd0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec              <= 2'd0;
                        a_out            <= 1'b0;
                        b_out            <= 1'b0;
                        settle_cnt       <= 4'd0;
                        err_count        <= 3'd0;
                        first_fail_vec   <= 2'd0;
                        first_fail_valid <= 1'b0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        state            <= SETTLE;
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST)
                        state <= CHECK;
                end
                CHECK: begin
                    if (mism != '0) begin
                        err_count <= err_count + 3'd1;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    if (vec == 2'd3) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        // Next vector is driven at the same edge that samples this one
                        vec        <= vec_nxt;
                        a_out      <= vec_nxt[1];
                        b_out      <= vec_nxt[0];
                        settle_cnt <= 4'd0;
                        state      <= SETTLE;
                    end
                end
            endcase
        end
    end
endmodule
